// File: rtl/lock_pkg.sv
// Shared state encoding, direction constants and duration helper for lock_seq.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREP      = 3'd1,
        ST_ENTRY     = 3'd2,
        ST_ENTRY_SET = 3'd3,
        ST_MOVE      = 3'd4,
        ST_EXIT      = 3'd5,
        ST_EXIT_SET  = 3'd6
    } lock_state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Cycles a state lasts; untimed states report 1 so the timer loads zero.
    function automatic int unsigned state_duration(
        input lock_state_e st,
        input logic        dir,
        input int unsigned fill,
        input int unsigned drain,
        input int unsigned settle,
        input int unsigned timeout
    );
        int unsigned n;
        n = 1;
        case (st)
            ST_PREP:                  n = (dir == DIR_UP) ? drain : fill;
            ST_MOVE:                  n = (dir == DIR_UP) ? fill : drain;
            ST_ENTRY_SET, ST_EXIT_SET: n = settle;
            ST_ENTRY:                 n = timeout;
            default:                  n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lock_seq_interval_timer.sv
// Shared down-counter for lock_seq; done stays high at zero until the next load.
module interval_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lock_seq.sv
// Canal-lock sequencer: arbitrates up/down passages, drives gates and valves from one timer.
// Optional entry-wait timeout is enabled by defining LOCK_TIMEOUT_EN.
module lock_seq
    import lock_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int unsigned FILL_CYCLES    = 8,
    parameter int unsigned DRAIN_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic req_up,
    input  logic req_down,
    input  logic boat_in,
    input  logic boat_out,
    output logic low_gate,
    output logic high_gate,
    output logic fill_valve,
    output logic drain_valve,
    output logic busy,
    output logic level_high,
    output logic fault
);

    lock_state_e      state_q, state_d;
    logic             dir_q, dir_d;
    logic             level_q, level_d;
    logic             pend_up_q, pend_up_d;
    logic             pend_dn_q, pend_dn_d;
    logic             eff_up, eff_dn;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;
`ifdef LOCK_TIMEOUT_EN
    logic             fault_q, fault_d;
`endif

    interval_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        level_d   = level_q;
        eff_up    = pend_up_q | req_up;
        eff_dn    = pend_dn_q | req_down;
        pend_up_d = eff_up;
        pend_dn_d = eff_dn;
`ifdef LOCK_TIMEOUT_EN
        fault_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (eff_up || eff_dn) begin
                    // With both waiting, serve whichever side matches the current level.
                    if (eff_up && eff_dn) begin
                        dir_d = level_q ? DIR_DN : DIR_UP;
                    end else begin
                        dir_d = eff_dn ? DIR_DN : DIR_UP;
                    end
                    if (dir_d == DIR_UP) begin
                        pend_up_d = 1'b0;
                    end else begin
                        pend_dn_d = 1'b0;
                    end
                    state_d = (level_q == (dir_d == DIR_DN)) ? ST_ENTRY : ST_PREP;
                end
            end
            ST_PREP: begin
                if (timer_done) begin
                    level_d = (dir_q == DIR_DN);
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (boat_in) begin
                    state_d = ST_ENTRY_SET;
                end
`ifdef LOCK_TIMEOUT_EN
                else if (timer_done) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end
`endif
            end
            ST_ENTRY_SET: begin
                if (timer_done) begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (timer_done) begin
                    level_d = ~level_q;
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (boat_out) begin
                    state_d = ST_EXIT_SET;
                end
            end
            ST_EXIT_SET: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        timer_load = (state_d != state_q);
        timer_val  = CNT_W'(state_duration(state_d, dir_d, FILL_CYCLES, DRAIN_CYCLES,
                                           SETTLE_CYCLES, TIMEOUT_CYCLES) - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            level_q   <= 1'b0;
            pend_up_q <= 1'b0;
            pend_dn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            level_q   <= level_d;
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Gate/valve decode is purely from registered state, so at most one is ever high.
    always_comb begin
        low_gate    = 1'b0;
        high_gate   = 1'b0;
        fill_valve  = 1'b0;
        drain_valve = 1'b0;
        case (state_q)
            ST_PREP: begin
                if (dir_q == DIR_UP) drain_valve = 1'b1;
                else                 fill_valve  = 1'b1;
            end
            ST_ENTRY, ST_ENTRY_SET: begin
                if (dir_q == DIR_UP) low_gate  = 1'b1;
                else                 high_gate = 1'b1;
            end
            ST_MOVE: begin
                if (dir_q == DIR_UP) fill_valve  = 1'b1;
                else                 drain_valve = 1'b1;
            end
            ST_EXIT, ST_EXIT_SET: begin
                if (dir_q == DIR_UP) high_gate = 1'b1;
                else                 low_gate  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign level_high = level_q;

endmodule

// File: tb/tb_lock_seq.sv
// Self-checking bench for lock_seq: a passage-schedule model checked every cycle plus directed checks.
// Define LOCK_TIMEOUT_EN for both RTL and bench to exercise the entry timeout.
module tb_lock_seq;

    // Fill and drain deliberately differ so a swapped valve duration shows up.
    localparam int FILL    = 8;
    localparam int DRAIN   = 6;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic req_up   = 1'b0;
    logic req_down = 1'b0;
    logic boat_in  = 1'b0;
    logic boat_out = 1'b0;
    logic low_gate, high_gate, fill_valve, drain_valve, busy, level_high, fault;

    int testsRun    = 0;
    int testsFailed = 0;
    bit cmpEnable   = 1'b0;

    lock_seq #(
        .CNT_W          (32),
        .FILL_CYCLES    (FILL),
        .DRAIN_CYCLES   (DRAIN),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_up      (req_up),
        .req_down    (req_down),
        .boat_in     (boat_in),
        .boat_out    (boat_out),
        .low_gate    (low_gate),
        .high_gate   (high_gate),
        .fill_valve  (fill_valve),
        .drain_valve (drain_valve),
        .busy        (busy),
        .level_high  (level_high),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // A passage is a list of segments, each showing one gate/valve pattern {low,high,fill,drain}.
    typedef enum {SEG_TIMED, SEG_WAIT_IN, SEG_WAIT_OUT} seg_kind_e;
    typedef struct {
        logic [3:0] outs;
        seg_kind_e  kind;
        int         len;
        int         levelFx;
    } seg_t;

    seg_t sched[$];
    int   segLeft = 0;
    int   waited  = 0;
    logic mLevel  = 1'b0;
    logic mPendUp = 1'b0;
    logic mPendDn = 1'b0;
    logic mFault  = 1'b0;
    logic mDn;
    logic effUp, effDn;

    function automatic seg_t mkSeg(input logic [3:0] o, input seg_kind_e k, input int n, input int fx);
        seg_t s;
        s.outs = o; s.kind = k; s.len = n; s.levelFx = fx;
        return s;
    endfunction

    task automatic startService(input logic dn);
        logic [3:0] entryGate, exitGate, moveValve;
        entryGate = dn ? 4'b0100 : 4'b1000;
        exitGate  = dn ? 4'b1000 : 4'b0100;
        moveValve = dn ? 4'b0001 : 4'b0010;
        sched.delete();
        if (mLevel != dn)
            sched.push_back(mkSeg(dn ? 4'b0010 : 4'b0001, SEG_TIMED, dn ? FILL : DRAIN, dn ? 2 : 1));
        sched.push_back(mkSeg(entryGate, SEG_WAIT_IN, 0, 0));
        sched.push_back(mkSeg(entryGate, SEG_TIMED, SETTLE, 0));
        sched.push_back(mkSeg(moveValve, SEG_TIMED, dn ? DRAIN : FILL, 3));
        sched.push_back(mkSeg(exitGate, SEG_WAIT_OUT, 0, 0));
        sched.push_back(mkSeg(exitGate, SEG_TIMED, SETTLE, 0));
        segLeft = sched[0].len;
        waited  = 0;
    endtask

    task automatic finishSeg();
        case (sched[0].levelFx)
            1: mLevel = 1'b0;
            2: mLevel = 1'b1;
            3: mLevel = ~mLevel;
            default: ;
        endcase
        void'(sched.pop_front());
        if (sched.size() != 0) segLeft = sched[0].len;
        waited = 0;
    endtask

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (reset) begin
            sched.delete();
            mLevel  = 1'b0;
            mPendUp = 1'b0;
            mPendDn = 1'b0;
            mFault  = 1'b0;
        end else begin
            mFault  = 1'b0;
            effUp   = mPendUp | req_up;
            effDn   = mPendDn | req_down;
            mPendUp = effUp;
            mPendDn = effDn;
            if (sched.size() == 0) begin
                if (effUp || effDn) begin
                    mDn = (effUp && effDn) ? mLevel : effDn;
                    if (mDn) mPendDn = 1'b0;
                    else     mPendUp = 1'b0;
                    startService(mDn);
                end
            end else begin
                case (sched[0].kind)
                    SEG_TIMED: begin
                        segLeft--;
                        if (segLeft == 0) finishSeg();
                    end
                    SEG_WAIT_IN: begin
                        if (boat_in) begin
                            finishSeg();
                        end else begin
`ifdef LOCK_TIMEOUT_EN
                            waited++;
                            if (waited == TIMEOUT) begin
                                sched.delete();
                                mFault = 1'b1;
                            end
`endif
                        end
                    end
                    SEG_WAIT_OUT: if (boat_out) finishSeg();
                endcase
            end
        end
    end

    logic [6:0] expVec, actVec;

    always @(negedge clk) begin
        if (cmpEnable) begin
            expVec = {(sched.size() != 0) ? sched[0].outs : 4'b0000,
                      sched.size() != 0, mLevel, mFault};
            actVec = {low_gate, high_gate, fill_valve, drain_valve, busy, level_high, fault};
            testsRun++;
            if (actVec !== expVec) begin
                testsFailed++;
                $display("[TB] FAIL cycle_check t=%0t got {lo,hi,fill,drain,busy,lvl,fault}=%b expected %b",
                         $time, actVec, expVec);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic up, input logic dn, input logic bin, input logic bout);
        req_up = up; req_down = dn; boat_in = bin; boat_out = bout;
        @(negedge clk);
        req_up = 1'b0; req_down = 1'b0; boat_in = 1'b0; boat_out = 1'b0;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0: return low_gate;
            1: return high_gate;
            2: return fill_valve;
            3: return drain_valve;
            default: return busy;
        endcase
    endfunction

    task automatic measureHigh(input int which, output int n);
        n = 0;
        while (sig(which) === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int allOuts();
        return int'({low_gate, high_gate, fill_valve, drain_valve, busy, level_high, fault});
    endfunction

    initial begin
        int n;
        @(posedge clk);
        cmpEnable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", allOuts(), 0);

        // Up passage from low level; stray sensor pulses must be ignored.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("stray_sensors_idle", busy, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_low_gate_next_cycle", low_gate, 1);
        checkOutput("t1_no_prep_fill", fill_valve, 0);
        repeat (3) @(negedge clk);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t1_boat_out_ignored", low_gate, 1);
        applyStimulus(0, 0, 1, 0);
        measureHigh(0, n);
        checkOutput("t1_entry_settle", n, SETTLE);
        measureHigh(2, n);
        checkOutput("t1_fill_cycles", n, FILL);
        checkOutput("t1_high_gate", high_gate, 1);
        checkOutput("t1_level_high", level_high, 1);
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 0, 1);
        measureHigh(1, n);
        checkOutput("t1_exit_settle", n, SETTLE);
        checkOutput("t1_idle", busy, 0);

        // Up passage from high level needs a drain first; req_down arrives mid-move.
        applyStimulus(1, 0, 0, 0);
        checkOutput("t2_prep_drain", drain_valve, 1);
        checkOutput("t2_gate_shut_in_prep", low_gate, 0);
        measureHigh(3, n);
        checkOutput("t2_drain_cycles", n, DRAIN);
        checkOutput("t2_low_gate_after_prep", low_gate, 1);
        checkOutput("t2_level_low_after_prep", level_high, 0);
        applyStimulus(0, 0, 1, 0);
        measureHigh(0, n);
        checkOutput("t2_entry_settle", n, SETTLE);
        applyStimulus(0, 1, 0, 0);
        measureHigh(2, n);
        checkOutput("t2_fill_rest", n, FILL - 1);
        applyStimulus(0, 0, 0, 1);
        measureHigh(1, n);
        checkOutput("t2_exit_settle", n, SETTLE);
        checkOutput("t2_idle_gap", busy, 0);
        @(negedge clk);
        checkOutput("t4_down_entry_high_gate", high_gate, 1);
        checkOutput("t4_down_no_prep", fill_valve | drain_valve, 0);
        applyStimulus(0, 0, 1, 0);
        measureHigh(1, n);
        checkOutput("t4_entry_settle", n, SETTLE);
        measureHigh(3, n);
        checkOutput("t4_drain_cycles", n, DRAIN);
        checkOutput("t4_exit_low_gate", low_gate, 1);
        checkOutput("t4_level_low", level_high, 0);
        applyStimulus(0, 0, 0, 1);
        measureHigh(0, n);
        checkOutput("t4_exit_settle", n, SETTLE);
        checkOutput("t4_idle", busy, 0);

        // Simultaneous requests at low level: up first, then down with no prep.
        applyStimulus(1, 1, 0, 0);
        checkOutput("t3_up_first", low_gate, 1);
        applyStimulus(0, 0, 1, 0);
        measureHigh(0, n);
        measureHigh(2, n);
        checkOutput("t3_fill_cycles", n, FILL);
        applyStimulus(0, 0, 0, 1);
        measureHigh(1, n);
        checkOutput("t3_idle_gap", busy, 0);
        @(negedge clk);
        checkOutput("t3_down_high_gate", high_gate, 1);
        checkOutput("t3_down_no_prep", fill_valve, 0);

        // Reset in the middle of the down move.
        applyStimulus(0, 0, 1, 0);
        measureHigh(1, n);
        checkOutput("t5_in_move_drain", drain_valve, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_reset_outputs", allOuts(), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_stays_idle", busy, 0);

`ifdef LOCK_TIMEOUT_EN
        // No boat arrives: gate gives up after the timeout and pulses fault.
        applyStimulus(1, 0, 0, 0);
        measureHigh(0, n);
        checkOutput("t6_entry_timeout", n, TIMEOUT);
        checkOutput("t6_fault_pulse", fault, 1);
        checkOutput("t6_idle", busy, 0);
        @(negedge clk);
        checkOutput("t6_fault_one_cycle", fault, 0);
        checkOutput("t6_pending_dropped", busy, 0);
        checkOutput("t6_level_kept", level_high, 0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
